// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer handshakes and CDB broadcast bundle for cdb_arbiter
interface cdb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4
);
  logic              flush;

  logic              alu_valid;
  logic [ROB_W-1:0]  alu_rob_id;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              br_valid;
  logic [ROB_W-1:0]  br_rob_id;
  logic [DATA_W-1:0] br_data;
  logic              br_ready;

  logic              lsb_valid;
  logic [ROB_W-1:0]  lsb_rob_id;
  logic [DATA_W-1:0] lsb_data;
  logic              lsb_ready;

  logic              cdb_valid;
  logic [ROB_W-1:0]  cdb_rob_id;
  logic [DATA_W-1:0] cdb_data;
  logic [1:0]        cdb_src;
  logic [15:0]       cdb_busy_cycles;

  // Producer / snooper side
  modport master (
    output flush,
    output alu_valid, alu_rob_id, alu_data, input alu_ready,
    output br_valid,  br_rob_id,  br_data,  input br_ready,
    output lsb_valid, lsb_rob_id, lsb_data, input lsb_ready,
    input  cdb_valid, cdb_rob_id, cdb_data, cdb_src, cdb_busy_cycles
  );

  // Arbiter side
  modport slave (
    input  flush,
    input  alu_valid, alu_rob_id, alu_data, output alu_ready,
    input  br_valid,  br_rob_id,  br_data,  output br_ready,
    input  lsb_valid, lsb_rob_id, lsb_data, output lsb_ready,
    output cdb_valid, cdb_rob_id, cdb_data, cdb_src, cdb_busy_cycles
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter over three one-entry holding slots
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  cdb_arbiter_if.slave bus
);

  // Ports are indexed 0 = ALU, 1 = BR, 2 = LSB throughout
  logic [2:0]        in_valid;
  logic [ROB_W-1:0]  in_tag  [3];
  logic [DATA_W-1:0] in_data [3];

  logic [2:0]        held_q, held_d;
  logic [ROB_W-1:0]  tag_q   [3];
  logic [ROB_W-1:0]  tag_d   [3];
  logic [DATA_W-1:0] data_q  [3];
  logic [DATA_W-1:0] data_d  [3];
  logic [1:0]        last_q, last_d;

  logic              cdb_valid_q, cdb_valid_d;
  logic [ROB_W-1:0]  cdb_rob_q, cdb_rob_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [1:0]        cdb_src_q, cdb_src_d;
  logic [15:0]       busy_q, busy_d;

  logic [1:0]        p0, p1, p2;
  logic [1:0]        grant_idx;
  logic              grant_any;
  logic [2:0]        grant;
  logic [2:0]        ready;
  logic              multi_held;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign in_valid   = {bus.lsb_valid, bus.br_valid, bus.alu_valid};
  assign in_tag[0]  = bus.alu_rob_id;
  assign in_tag[1]  = bus.br_rob_id;
  assign in_tag[2]  = bus.lsb_rob_id;
  assign in_data[0] = bus.alu_data;
  assign in_data[1] = bus.br_data;
  assign in_data[2] = bus.lsb_data;

  // Round-robin pick: search starts just after the last granted port
  always_comb begin
    p0        = next_port(last_q);
    p1        = next_port(p0);
    p2        = next_port(p1);
    grant_any = 1'b1;
    grant_idx = p0;
    if (held_q[p0])      grant_idx = p0;
    else if (held_q[p1]) grant_idx = p1;
    else if (held_q[p2]) grant_idx = p2;
    else                 grant_any = 1'b0;
    grant = grant_any ? (3'b001 << grant_idx) : 3'b000;
  end

  // A slot accepts when empty or being drained this cycle; flush blocks all intake
  assign ready      = bus.flush ? 3'b000 : (~held_q | grant);
  assign multi_held = (held_q[0] & held_q[1]) | (held_q[0] & held_q[2]) | (held_q[1] & held_q[2]);

  // Next-state: broadcast the grant, drain it, then let new captures override the drain
  always_comb begin
    held_d      = held_q;
    tag_d       = tag_q;
    data_d      = data_q;
    last_d      = last_q;
    cdb_valid_d = 1'b0;
    cdb_rob_d   = cdb_rob_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    busy_d      = busy_q;
    if (bus.flush) begin
      held_d = 3'b000;
    end else begin
      if (multi_held && (busy_q != 16'hFFFF)) busy_d = busy_q + 16'd1;
      if (grant_any) begin
        cdb_valid_d       = 1'b1;
        cdb_rob_d         = tag_q[grant_idx];
        cdb_data_d        = data_q[grant_idx];
        cdb_src_d         = grant_idx;
        held_d[grant_idx] = 1'b0;
        last_d            = grant_idx;
      end
      // Tag 0 completes the handshake but carries nothing worth broadcasting
      for (int i = 0; i < 3; i++) begin
        if (in_valid[i] && ready[i] && (in_tag[i] != '0)) begin
          held_d[i] = 1'b1;
          tag_d[i]  = in_tag[i];
          data_d[i] = in_data[i];
        end
      end
    end
  end

  // State registers; reset empties every slot immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q      <= 3'b000;
      tag_q       <= '{default: '0};
      data_q      <= '{default: '0};
      last_q      <= 2'd2;
      cdb_valid_q <= 1'b0;
      cdb_rob_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= 2'd0;
      busy_q      <= 16'd0;
    end else begin
      held_q      <= held_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      last_q      <= last_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_rob_q   <= cdb_rob_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.alu_ready       = ready[0];
  assign bus.br_ready        = ready[1];
  assign bus.lsb_ready       = ready[2];
  assign bus.cdb_valid       = cdb_valid_q;
  assign bus.cdb_rob_id      = cdb_rob_q;
  assign bus.cdb_data        = cdb_data_q;
  assign bus.cdb_src         = cdb_src_q;
  assign bus.cdb_busy_cycles = busy_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter with a behavioural slot model
module tb_cdb_arbiter;
  localparam int DW = 32;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.DATA_W(DW), .ROB_W(RW)) bus ();
  cdb_arbiter #(.DATA_W(DW), .ROB_W(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Stimulus: what each producer currently offers
  bit          pv [3];
  logic [3:0]  pt [3];
  logic [31:0] pd [3];
  bit          fl;

  // Reference model
  bit          mh [3];
  logic [3:0]  mt [3];
  logic [31:0] md [3];
  int          mlast;
  bit          mcv;
  logic [3:0]  mcid;
  logic [31:0] mcd;
  int          mcs;
  int          mbusy;
  bit          mr [3];
  bit          seen_rdy [3];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic rdy(input int i);
    case (i)
      0:       return bus.alu_ready;
      1:       return bus.br_ready;
      default: return bus.lsb_ready;
    endcase
  endfunction

  function automatic int m_grant();
    int g = -1;
    for (int k = 1; k <= 3; k++) begin
      int idx = (mlast + k) % 3;
      if (g < 0 && mh[idx]) g = idx;
    end
    return g;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mh[i] = 0;
    mlast = 2; mcv = 0; mcid = '0; mcd = '0; mcs = 0; mbusy = 0;
  endtask

  task automatic apply();
    bus.flush      = fl;
    bus.alu_valid  = pv[0]; bus.alu_rob_id = pt[0]; bus.alu_data = pd[0];
    bus.br_valid   = pv[1]; bus.br_rob_id  = pt[1]; bus.br_data  = pd[1];
    bus.lsb_valid  = pv[2]; bus.lsb_rob_id = pt[2]; bus.lsb_data = pd[2];
  endtask

  // One clock: check readies before the edge, advance the model, check CDB after it
  task automatic cycle();
    int g;
    int nheld;
    apply();
    #1;
    g = m_grant();
    for (int i = 0; i < 3; i++) begin
      mr[i] = !fl && (!mh[i] || g == i);
      seen_rdy[i] = rdy(i);
      chk($sformatf("ready%0d", i), 32'(seen_rdy[i]), 32'(mr[i]));
    end
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < 3; i++) mh[i] = 0;
      mcv = 0;
    end else begin
      nheld = int'(mh[0]) + int'(mh[1]) + int'(mh[2]);
      if (nheld > 1 && mbusy < 65535) mbusy++;
      if (g >= 0) begin
        mcv = 1; mcid = mt[g]; mcd = md[g]; mcs = g; mh[g] = 0; mlast = g;
      end else begin
        mcv = 0;
      end
      for (int i = 0; i < 3; i++)
        if (pv[i] && mr[i] && pt[i] != 4'd0) begin
          mh[i] = 1; mt[i] = pt[i]; md[i] = pd[i];
        end
    end
    #1;
    chk("cdb_valid", 32'(bus.cdb_valid), 32'(mcv));
    chk("cdb_rob_id", 32'(bus.cdb_rob_id), 32'(mcid));
    chk("cdb_data", bus.cdb_data, mcd);
    chk("cdb_src", 32'(bus.cdb_src), 32'(mcs));
    chk("busy", 32'(bus.cdb_busy_cycles), 32'(mbusy));
    @(negedge clk);
  endtask

  // A producer refreshes its offer only once the previous one was taken
  task automatic advance(input int prob, input bit zero_ok);
    for (int i = 0; i < 3; i++)
      if (!pv[i] || mr[i]) begin
        pv[i] = ($urandom_range(99) < prob);
        pt[i] = zero_ok ? 4'($urandom_range(15)) : 4'($urandom_range(15, 1));
        pd[i] = $urandom;
      end
  endtask

  // Reset pulse strictly between clock edges
  task automatic areset();
    for (int i = 0; i < 3; i++) pv[i] = 0;
    fl = 0;
    apply();
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("arst_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("arst_br_ready", 32'(bus.br_ready), 32'd1);
    chk("arst_lsb_ready", 32'(bus.lsb_ready), 32'd1);
    chk("arst_busy", 32'(bus.cdb_busy_cycles), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_port(input int i, input bit v, input logic [3:0] t, input logic [31:0] d);
    pv[i] = v; pt[i] = t; pd[i] = d;
  endtask

  initial begin
    rst = 1'b1;
    fl  = 0;
    for (int i = 0; i < 3; i++) set_port(i, 0, 4'd0, 32'd0);
    apply();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("rst_cdb_rob_id", 32'(bus.cdb_rob_id), 32'd0);
    chk("rst_cdb_data", bus.cdb_data, 32'd0);
    chk("rst_cdb_src", 32'(bus.cdb_src), 32'd0);
    chk("rst_busy", 32'(bus.cdb_busy_cycles), 32'd0);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    rst = 1'b0;

    // Single ALU result
    set_port(0, 1, 4'd3, 32'h11);
    cycle();
    set_port(0, 0, 4'd0, 32'd0);
    cycle();
    chk("single_valid", 32'(bus.cdb_valid), 32'd1);
    chk("single_tag", 32'(bus.cdb_rob_id), 32'd3);
    chk("single_data", bus.cdb_data, 32'h11);
    chk("single_src", 32'(bus.cdb_src), 32'd0);
    chk("single_ready", 32'(seen_rdy[0]), 32'd1);

    // Back-to-back ALU stream
    for (int k = 1; k <= 3; k++) begin
      set_port(0, 1, 4'(k), 32'(k * 16));
      cycle();
      chk("b2b_ready", 32'(seen_rdy[0]), 32'd1);
      if (k > 1) chk("b2b_tag", 32'(bus.cdb_rob_id), 32'(k - 1));
    end
    set_port(0, 0, 4'd0, 32'd0);
    cycle();
    chk("b2b_last_tag", 32'(bus.cdb_rob_id), 32'd3);
    chk("b2b_last_valid", 32'(bus.cdb_valid), 32'd1);

    // Full contention from a fresh pointer
    areset();
    set_port(0, 1, 4'd4, 32'h40);
    set_port(1, 1, 4'd5, 32'h50);
    set_port(2, 1, 4'd6, 32'h60);
    cycle();
    for (int k = 0; k < 6; k++) begin
      advance(100, 0);
      cycle();
      chk("cont_src", 32'(bus.cdb_src), 32'(k % 3));
      chk("cont_busy", 32'(bus.cdb_busy_cycles), 32'(k + 1));
      chk("cont_ready_count", 32'(int'(seen_rdy[0]) + int'(seen_rdy[1]) + int'(seen_rdy[2])), 32'd1);
      if (k == 0) chk("cont_first_tag", 32'(bus.cdb_rob_id), 32'd4);
    end

    // Reset in the middle of contention, then port 0 wins first
    areset();
    set_port(0, 1, 4'd7, 32'h70);
    set_port(1, 1, 4'd8, 32'h80);
    set_port(2, 1, 4'd9, 32'h90);
    cycle();
    for (int i = 0; i < 3; i++) set_port(i, 0, 4'd0, 32'd0);
    cycle();
    chk("post_rst_src", 32'(bus.cdb_src), 32'd0);
    chk("post_rst_tag", 32'(bus.cdb_rob_id), 32'd7);
    cycle();
    cycle();

    // Fairness: after a BR grant, LSB beats ALU
    set_port(1, 1, 4'd5, 32'h55);
    cycle();
    set_port(1, 0, 4'd0, 32'd0);
    set_port(0, 1, 4'd6, 32'h66);
    set_port(2, 1, 4'd7, 32'h77);
    cycle();
    chk("rr_br_src", 32'(bus.cdb_src), 32'd1);
    set_port(0, 0, 4'd0, 32'd0);
    set_port(2, 0, 4'd0, 32'd0);
    cycle();
    chk("rr_lsb_first", 32'(bus.cdb_src), 32'd2);
    cycle();
    chk("rr_alu_second", 32'(bus.cdb_src), 32'd0);

    // Flush with ALU and LSB held and BR offering
    set_port(0, 1, 4'd10, 32'hA0);
    set_port(2, 1, 4'd11, 32'hB0);
    cycle();
    set_port(0, 0, 4'd0, 32'd0);
    set_port(2, 0, 4'd0, 32'd0);
    set_port(1, 1, 4'd12, 32'hC0);
    fl = 1;
    cycle();
    chk("flush_br_ready", 32'(seen_rdy[1]), 32'd0);
    chk("flush_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    fl = 0;
    set_port(1, 0, 4'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("flush_quiet", 32'(bus.cdb_valid), 32'd0);
    end

    // Tag 0 is accepted but never broadcast
    set_port(2, 1, 4'd0, 32'hDEAD);
    cycle();
    chk("tag0_ready", 32'(seen_rdy[2]), 32'd1);
    set_port(2, 0, 4'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("tag0_no_bcast", 32'(bus.cdb_valid), 32'd0);
    end

    // Random traffic with occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      fl = ($urandom_range(19) == 0);
      cycle();
      fl = 0;
      if ($urandom_range(99) == 0) areset();
      advance(60, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) between the three result producers: ALU executor (port 0), branch executor (port 1) and load/store buffer (port 2).
- Each producer has a one-entry holding register with a valid/ready handshake.
- Each cycle, one held result is chosen round-robin and broadcast on registered CDB outputs. The reservation station, load/store buffer and ROB snoop these outputs to clear Q tags and mark entries done.
- A flush input discards all pending results on mispredict rollback.

Parameters:
- DATA_W, 32, width of the result value.
- ROB_W, 4, width of the ROB tag. Tag 0 means "no dependency" and is never broadcast.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous rollback; discards all pending state.
- alu_valid  in  1  ALU result offered.
- alu_rob_id  in  ROB_W  ALU result tag.
- alu_data  in  DATA_W  ALU result value.
- alu_ready  out  1  ALU holding slot can accept this cycle.
- br_valid  in  1  branch result offered.
- br_rob_id  in  ROB_W  branch result tag.
- br_data  in  DATA_W  branch link value (pc+4).
- br_ready  out  1  branch slot can accept.
- lsb_valid  in  1  load/store result offered.
- lsb_rob_id  in  ROB_W  load/store result tag.
- lsb_data  in  DATA_W  load data.
- lsb_ready  out  1  load/store slot can accept.
- cdb_valid  out  1  broadcast valid this cycle.
- cdb_rob_id  out  ROB_W  broadcast tag.
- cdb_data  out  DATA_W  broadcast value.
- cdb_src  out  2  source of the broadcast: 0 = ALU, 1 = BR, 2 = LSB.
- cdb_busy_cycles  out  16  saturating count of cycles in which at least one slot was left waiting.

Behaviour:
- Reset (async, rst=1):
  - all holding slots empty; cdb_valid=0; cdb_rob_id=0; cdb_data=0; cdb_src=0.
  - cdb_busy_cycles=0.
  - round-robin pointer last_grant=2, so port 0 has highest priority first.
  - rst asserted mid-operation drops all held results immediately, without waiting for a clock edge.
- Holding slot i state: held_i, tag_i, data_i.
- Grant (combinational, from state before the edge):
  - Candidates are the held slots.
  - Search order is last_grant+1, +2, +3, mod 3. The first held slot wins (grant_i=1).
  - At most one grant per cycle.
- Ready (combinational): ready_i = !flush && (!held_i || grant_i).
  - ready_i does not depend on valid_i.
  - A port therefore sustains one result per cycle while uncontested.
- Each rising edge, when flush=0:
  - If some grant_i: the cdb_* outputs load the slot's tag and data, cdb_src=i, cdb_valid=1, held_i clears, and last_grant=i.
  - If no grant: cdb_valid=0. cdb_rob_id, cdb_data and cdb_src hold their previous values. last_grant is unchanged.
  - If valid_i && ready_i: the slot captures the rob_id and data and held_i sets. This overrides the clear from a same-cycle grant of that slot.
  - If valid_i && ready_i with rob_id == 0: the handshake completes but the payload is discarded and held_i stays clear.
  - cdb_busy_cycles increments, saturating at 16'hFFFF, when more than one slot was held before the edge.
- Latency: a result accepted at edge k is broadcast at edge k+1 at the earliest.
  - With all three ports continuously contending, the worst-case wait is 3 edges after capture.
  - A producer whose valid was high while ready was low must hold valid and payload stable until it sees ready.
- Flush (sampled at an edge):
  - all slots clear; cdb_valid=0; inputs in that cycle are not captured (ready is forced low).
  - last_grant and cdb_busy_cycles are kept.
  - A broadcast already on the CDB outputs during the flush cycle remains valid for that cycle only.
- No backpressure from consumers: every cdb_valid=1 cycle is consumed.

Test Plan:
- After reset, a single ALU result tag=3 data=0x11: alu_valid for 1 cycle -> next cycle cdb_valid=1, rob_id=3, data=0x11, src=0; alu_ready stays 1 throughout.
- Back-to-back ALU results tags 1,2,3 with no other traffic -> three consecutive broadcast cycles with tags 1,2,3; alu_ready never drops.
- All three ports offer a result in the same cycle (tags 4,5,6), then keep offering new tags -> broadcast order src 0,1,2,0,1,2. Each port sees ready low for exactly 2 of every 3 cycles, and cdb_busy_cycles increments each contended cycle.
- Round-robin fairness: after a BR grant, ALU and LSB both held -> LSB (src=2) wins before ALU.
- Flush while ALU and LSB slots are held and br_valid=1 -> br_ready=0 in the flush cycle; cdb_valid=0 the following cycle; no held or offered result is ever broadcast.
- Async reset pulsed mid-contention (between edges) -> cdb_valid=0 and all ready=1 immediately; cdb_busy_cycles=0; next grant goes to port 0. Also: lsb_valid with rob_id=0 -> lsb_ready=1 and no broadcast follows.
